// File: rtl/freq_div_pkg.sv
// Shared types and constants for the multi-channel programmable frequency divider.
package freq_div_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_RATIO = 2;
  localparam int unsigned DEF_N_CH  = 4;
  localparam int unsigned DEF_CNT_W = 32;

  // Low bit of channel k inside a bus packed as N_CH fields of width w.
  function automatic int unsigned ch_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: IDLE/RUN FSM, period counter, double-buffered ratio/high
// registers and registered salida/tick/active outputs.
module freq_div_channel
  import freq_div_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_ratio,
  input  logic [CNT_W-1:0] i_high,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_sync,
  output logic             o_salida,
  output logic             o_tick,
  output logic             o_active
);

  state_t           r_state,      w_state_nx;
  logic [CNT_W-1:0] r_cnt,        w_cnt_nx;
  logic [CNT_W-1:0] r_ratio_q,    w_ratio_nx;
  logic [CNT_W-1:0] r_high_q,     w_high_nx;
  logic [CNT_W-1:0] r_pend_ratio, w_pend_ratio_nx;
  logic [CNT_W-1:0] r_pend_high,  w_pend_high_nx;
  logic             r_pend_valid, w_pend_valid_nx;
  logic             r_salida,     w_salida_nx;
  logic             r_tick,       w_tick_nx;
  logic             w_wrap;

  assign w_wrap = (r_cnt == r_ratio_q - CNT_W'(1));

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_ratio_nx      = r_ratio_q;
    w_high_nx       = r_high_q;
    w_pend_ratio_nx = r_pend_ratio;
    w_pend_high_nx  = r_pend_high;
    w_pend_valid_nx = r_pend_valid;

    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (i_load) begin
          w_ratio_nx = i_ratio;
          w_high_nx  = i_high;
        end
        if (i_en && (w_ratio_nx >= CNT_W'(MIN_RATIO))) begin
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (!i_en) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          if (i_load) begin
            w_pend_ratio_nx = i_ratio;
            w_pend_high_nx  = i_high;
            w_pend_valid_nx = 1'b1;
          end
        end else if (i_sync || w_wrap) begin
          // A load landing on the boundary edge supersedes any older shadow value.
          w_cnt_nx = '0;
          if (i_load) begin
            w_ratio_nx      = i_ratio;
            w_high_nx       = i_high;
            w_pend_valid_nx = 1'b0;
          end else if (r_pend_valid) begin
            w_ratio_nx      = r_pend_ratio;
            w_high_nx       = r_pend_high;
            w_pend_valid_nx = 1'b0;
          end
          if (w_ratio_nx < CNT_W'(MIN_RATIO)) begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
          if (i_load) begin
            w_pend_ratio_nx = i_ratio;
            w_pend_high_nx  = i_high;
            w_pend_valid_nx = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase

    w_salida_nx = (w_state_nx == S_RUN) && (w_cnt_nx < w_high_nx);
    w_tick_nx   = (w_state_nx == S_RUN) && (w_cnt_nx == w_ratio_nx - CNT_W'(1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ratio_q    <= '0;
      r_high_q     <= '0;
      r_pend_ratio <= '0;
      r_pend_high  <= '0;
      r_pend_valid <= 1'b0;
      r_salida     <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_ratio_q    <= w_ratio_nx;
      r_high_q     <= w_high_nx;
      r_pend_ratio <= w_pend_ratio_nx;
      r_pend_high  <= w_pend_high_nx;
      r_pend_valid <= w_pend_valid_nx;
      r_salida     <= w_salida_nx;
      r_tick       <= w_tick_nx;
    end
  end

  assign o_salida = r_salida;
  assign o_tick   = r_tick;
  assign o_active = (r_state == S_RUN);

endmodule

// File: rtl/freq_divider_multi.sv
// N_CH independent programmable dividers off one clock, sharing a global sync.
module freq_divider_multi
  import freq_div_pkg::*;
#(
  parameter int unsigned N_CH  = DEF_N_CH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                  entrada,
  input  logic                  reset,
  input  logic [N_CH*CNT_W-1:0] ratio_in,
  input  logic [N_CH*CNT_W-1:0] high_in,
  input  logic [N_CH-1:0]       load,
  input  logic [N_CH-1:0]       en,
  input  logic                  sync,
  output logic [N_CH-1:0]       salida,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       active
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    freq_div_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .i_clk    (entrada),
      .i_rst    (reset),
      .i_ratio  (ratio_in[ch_lo(k, CNT_W) +: CNT_W]),
      .i_high   (high_in[ch_lo(k, CNT_W) +: CNT_W]),
      .i_load   (load[k]),
      .i_en     (en[k]),
      .i_sync   (sync),
      .o_salida (salida[k]),
      .o_tick   (tick[k]),
      .o_active (active[k])
    );
  end

endmodule

// File: tb/tb_freq_divider_multi.sv
// Directed and randomized checks of freq_divider_multi against a period-level channel model.
module tb_freq_divider_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic                  entrada  = 1'b0;
  logic                  reset    = 1'b0;
  logic [N_CH*CNT_W-1:0] ratio_in = '0;
  logic [N_CH*CNT_W-1:0] high_in  = '0;
  logic [N_CH-1:0]       load     = '0;
  logic [N_CH-1:0]       en       = '0;
  logic                  sync     = 1'b0;
  logic [N_CH-1:0]       salida, tick, active;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model: is the channel running, where it is in its period, active/pending settings.
  int m_run[N_CH], m_pos[N_CH], m_ratio[N_CH], m_high[N_CH];
  int m_pr[N_CH], m_ph[N_CH], m_pv[N_CH];

  freq_divider_multi #(
    .N_CH (N_CH),
    .CNT_W(CNT_W)
  ) dut (
    .entrada (entrada),
    .reset   (reset),
    .ratio_in(ratio_in),
    .high_in (high_in),
    .load    (load),
    .en      (en),
    .sync    (sync),
    .salida  (salida),
    .tick    (tick),
    .active  (active)
  );

  always #5 entrada = ~entrada;

  function automatic void model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_run[k] = 0; m_pos[k] = 0; m_ratio[k] = 0; m_high[k] = 0;
      m_pr[k] = 0; m_ph[k] = 0; m_pv[k] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < N_CH; k++) begin
      int ri, hi;
      ri = int'(ratio_in[k*CNT_W +: CNT_W]);
      hi = int'(high_in[k*CNT_W +: CNT_W]);
      if (m_run[k] == 0) begin
        if (load[k]) begin m_ratio[k] = ri; m_high[k] = hi; end
        m_pos[k] = 0;
        if (en[k] && m_ratio[k] >= 2) m_run[k] = 1;
      end else if (!en[k]) begin
        if (load[k]) begin m_pr[k] = ri; m_ph[k] = hi; m_pv[k] = 1; end
        m_run[k] = 0;
        m_pos[k] = 0;
      end else if (sync || m_pos[k] == m_ratio[k] - 1) begin
        if (load[k]) begin
          m_ratio[k] = ri; m_high[k] = hi; m_pv[k] = 0;
        end else if (m_pv[k] != 0) begin
          m_ratio[k] = m_pr[k]; m_high[k] = m_ph[k]; m_pv[k] = 0;
        end
        m_pos[k] = 0;
        if (m_ratio[k] < 2) m_run[k] = 0;
      end else begin
        if (load[k]) begin m_pr[k] = ri; m_ph[k] = hi; m_pv[k] = 1; end
        m_pos[k] = m_pos[k] + 1;
      end
    end
  endfunction

  function automatic logic [N_CH-1:0] exp_salida();
    logic [N_CH-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k] = (m_run[k] != 0) && (m_pos[k] < m_high[k]);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_tick();
    logic [N_CH-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k] = (m_run[k] != 0) && (m_pos[k] == m_ratio[k] - 1);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_active();
    logic [N_CH-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k] = (m_run[k] != 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model with the inputs presented, then compare all outputs.
  task automatic step();
    model_edge();
    @(posedge entrada);
    #1;
    check("salida", salida, exp_salida());
    check("tick",   tick,   exp_tick());
    check("active", active, exp_active());
  endtask

  task automatic set_ch(input int k, input int r, input int h);
    ratio_in[k*CNT_W +: CNT_W] = CNT_W'(r);
    high_in[k*CNT_W +: CNT_W]  = CNT_W'(h);
  endtask

  initial begin
    logic [3:0] pat_s4;
    logic [3:0] pat_t4;
    logic [2:0] pat_s3;
    logic [2:0] pat_t3;
    int         n;
    pat_s4 = 4'b0011; pat_t4 = 4'b1000;
    pat_s3 = 3'b001;  pat_t3 = 3'b100;
    model_reset();

    // Reset acts before any clock edge.
    #1 reset = 1'b1;
    #2;
    check("rst_salida", salida, '0);
    check("rst_tick",   tick,   '0);
    check("rst_active", active, '0);
    @(posedge entrada); #1;
    reset = 1'b0;

    // ch0 ratio 4, high 2.
    set_ch(0, 4, 2); load = 4'b0001; en = 4'b0001;
    step();
    load = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      lit("t1_salida", salida[0], pat_s4[i%4]);
      lit("t1_tick",   tick[0],   pat_t4[i%4]);
    end
    check("t1_active", active, 4'b0001);

    // ch1 ratio 5, high 0, then reload high 7 mid-run.
    set_ch(1, 5, 0); load = 4'b0010; en = 4'b0011;
    step();
    load = '0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      lit("t2_zero", salida[1], 1'b0);
      if (tick[1]) n++;
      step();
    end
    lit("t2_tickcnt", n == 2, 1'b1);
    set_ch(1, 5, 7); load = 4'b0010;
    step();
    load = '0;
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 5; i++) begin
      step();
      lit("t2_one", salida[1], 1'b1);
    end

    // ch0 ratio 8, reload ratio 3 / high 1 at cnt 2.
    en[0] = 1'b0;
    step();
    set_ch(0, 8, 4); load = 4'b0001; en[0] = 1'b1;
    step();
    load = '0;
    step(); step();
    set_ch(0, 3, 1); load = 4'b0001;
    step();
    load = '0;
    n = 0;
    while (!tick[0] && n < 20) begin
      step();
      n++;
    end
    lit("t3_remaining", n == 4, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      lit("t3_salida", salida[0], pat_s3[i%3]);
      lit("t3_tick",   tick[0],   pat_t3[i%3]);
    end

    // ch3 invalid ratio, then enable drop at cnt 3 and restart.
    set_ch(3, 1, 1); load = 4'b1000; en[3] = 1'b1;
    step();
    load = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      lit("t4_idle_act", active[3], 1'b0);
      lit("t4_idle_sal", salida[3], 1'b0);
    end
    set_ch(3, 6, 3); load = 4'b1000;
    step();
    load = '0;
    step(); step(); step();
    en[3] = 1'b0;
    step();
    lit("t4_drop_act",  active[3], 1'b0);
    lit("t4_drop_sal",  salida[3], 1'b0);
    lit("t4_drop_tick", tick[3],   1'b0);
    en[3] = 1'b1;
    step();
    lit("t4_re_act", active[3], 1'b1);
    lit("t4_re_sal", salida[3], 1'b1);

    // Sync aligns ch0 (ratio 4) and ch2 (ratio 6).
    set_ch(0, 4, 2); set_ch(2, 6, 3); load = 4'b0101; en[2] = 1'b1;
    step();
    load = '0;
    for (int i = 0; i < 5 + int'($urandom_range(0, 7)); i++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    lit("t5_sal0", salida[0], 1'b1);
    lit("t5_sal2", salida[2], 1'b1);
    for (int k = 2; k <= 6; k++) begin
      step();
      lit("t5_tick0", tick[0], k == 4);
      lit("t5_tick2", tick[2], k == 6);
    end

    // Asynchronous reset mid-cycle, then no load: nothing may start.
    #2 reset = 1'b1;
    #1;
    check("ar_salida", salida, '0);
    check("ar_tick",   tick,   '0);
    check("ar_active", active, '0);
    model_reset();
    #1 reset = 1'b0;
    en = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar_idle", active, '0);
    end

    // Randomized traffic, including the maximum ratio.
    for (int c = 0; c < 3000; c++) begin
      load = '0;
      for (int k = 0; k < N_CH; k++) begin
        if ($urandom_range(0, 24) == 0) begin
          int r, h;
          r = ($urandom_range(0, 39) == 0) ? 255 : int'($urandom_range(0, 9));
          h = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 12));
          set_ch(k, r, h);
          load[k] = 1'b1;
        end
        if ($urandom_range(0, 49) == 0) en[k] = ~en[k];
      end
      sync = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
